// File: rtl/ram_arbiter_pkg.sv
// Shared types and the round-robin pick helper for ram_arbiter.
package ram_arb_pkg;

  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned MAX_ID_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_e;

  typedef enum logic {
    RAM_OP_RD,
    RAM_OP_WR
  } ram_op_e;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] idx;
  } rr_pick_t;

  // First set request at or after ptr, wrapping at num_req; ptr = 0 gives fixed priority.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  req,
                                       input logic [MAX_ID_W-1:0] ptr,
                                       input int unsigned         num_req);
    rr_pick_t    pick;
    int unsigned cand;
    pick = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= num_req) cand = cand - num_req;
      if ((i < num_req) && !pick.valid && req[cand[MAX_ID_W-1:0]]) begin
        pick.valid = 1'b1;
        pick.idx   = cand[MAX_ID_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and ram-side signal bundle for ram_arbiter.
// slave = the arbiter, master = requesters plus the ram.
interface ram_arbiter_if #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned WORD_WIDTH  = 4,
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned REQ_ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

  logic [NUM_REQ-1:0]                  req_i;
  logic [NUM_REQ-1:0]                  req_we_i;
  logic [NUM_REQ-1:0][INDEX_WIDTH-1:0] req_index_i;
  logic [NUM_REQ-1:0][WORD_WIDTH-1:0]  req_wdata_i;
  logic [NUM_REQ-1:0]                  req_ack_o;
  logic [WORD_WIDTH-1:0]               req_rdata_o;
  logic                                busy_o;
  logic [REQ_ID_W-1:0]                 gnt_id_o;

  logic                                ram_wr_o;
  logic                                ram_ack_wr_i;
  logic [WORD_WIDTH-1:0]               ram_wr_data_o;
  logic [INDEX_WIDTH-1:0]              ram_wr_index_o;
  logic                                ram_rd_o;
  logic                                ram_ack_rd_i;
  logic [WORD_WIDTH-1:0]               ram_rd_data_i;
  logic [INDEX_WIDTH-1:0]              ram_rd_index_o;

  modport slave (
    input  req_i, req_we_i, req_index_i, req_wdata_i,
    input  ram_ack_wr_i, ram_ack_rd_i, ram_rd_data_i,
    output req_ack_o, req_rdata_o, busy_o, gnt_id_o,
    output ram_wr_o, ram_wr_data_o, ram_wr_index_o, ram_rd_o, ram_rd_index_o
  );

  modport master (
    output req_i, req_we_i, req_index_i, req_wdata_i,
    output ram_ack_wr_i, ram_ack_rd_i, ram_rd_data_i,
    input  req_ack_o, req_rdata_o, busy_o, gnt_id_o,
    input  ram_wr_o, ram_wr_data_o, ram_wr_index_o, ram_rd_o, ram_rd_index_o
  );

endinterface

// File: rtl/ram_arbiter_rr_arbiter.sv
// Combinational winner pick from a request vector and a start pointer.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned REQ_ID_W = 1
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [REQ_ID_W-1:0] ptr,
  output logic                gnt_valid_c,
  output logic [REQ_ID_W-1:0] gnt_id_c
);

  rr_pick_t pick;

  // Search from ptr upward with wrap; ids fit REQ_ID_W since NUM_REQ <= 2**REQ_ID_W.
  always_comb begin
    pick        = rr_pick(MAX_REQ'(req), MAX_ID_W'(ptr), NUM_REQ);
    gnt_valid_c = pick.valid;
    gnt_id_c    = REQ_ID_W'(pick.idx);
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one ram between NUM_REQ requesters, one transaction at a time.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins)
// instead of round-robin.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned WORD_WIDTH  = 4,
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned REQ_ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic          clk_i,
  input logic          arstn_i,
  ram_arbiter_if.slave bus
);

  arb_state_e             state_q;
  ram_op_e                op_q;
  logic [REQ_ID_W-1:0]    gnt_q;
  logic [NUM_REQ-1:0]     ack_q;
  logic [WORD_WIDTH-1:0]  rdata_q;
  logic                   busy_q;
  logic                   ram_wr_q;
  logic                   ram_rd_q;
  logic [WORD_WIDTH-1:0]  wr_data_q;
  logic [INDEX_WIDTH-1:0] wr_index_q;
  logic [INDEX_WIDTH-1:0] rd_index_q;

  logic [REQ_ID_W-1:0]    ptr_c;
  logic                   pick_valid_c;
  logic [REQ_ID_W-1:0]    pick_id_c;
  logic                   ack_match_c;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign ptr_c = '0;
`else
  logic [REQ_ID_W-1:0] rr_q;
  assign ptr_c = rr_q;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .REQ_ID_W(REQ_ID_W)
  ) u_rr_arbiter (
    .req        (bus.req_i),
    .ptr        (ptr_c),
    .gnt_valid_c(pick_valid_c),
    .gnt_id_c   (pick_id_c)
  );

  // Only the ack of the op in flight completes it; the other ack is ignored.
  assign ack_match_c = (op_q == RAM_OP_WR) ? bus.ram_ack_wr_i : bus.ram_ack_rd_i;

  // Arbitration FSM: latch winner in IDLE, strobe in ISSUE, wait for ack, pulse ack in DONE.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= IDLE;
      op_q       <= RAM_OP_RD;
      gnt_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      ram_wr_q   <= 1'b0;
      ram_rd_q   <= 1'b0;
      wr_data_q  <= '0;
      wr_index_q <= '0;
      rd_index_q <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      rr_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid_c) begin
            gnt_q   <= pick_id_c;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
            if (bus.req_we_i[pick_id_c]) begin
              op_q       <= RAM_OP_WR;
              ram_wr_q   <= 1'b1;
              wr_index_q <= bus.req_index_i[pick_id_c];
              wr_data_q  <= bus.req_wdata_i[pick_id_c];
            end else begin
              op_q       <= RAM_OP_RD;
              ram_rd_q   <= 1'b1;
              rd_index_q <= bus.req_index_i[pick_id_c];
            end
          end
        end
        ISSUE: begin
          ram_wr_q <= 1'b0;
          ram_rd_q <= 1'b0;
          state_q  <= WAIT;
        end
        WAIT: begin
          if (ack_match_c) begin
            ack_q[gnt_q] <= 1'b1;
            if (op_q == RAM_OP_RD) rdata_q <= bus.ram_rd_data_i;
`ifndef RAM_ARB_FIXED_PRIO_EN
            if (gnt_q == REQ_ID_W'(NUM_REQ - 1)) rr_q <= '0;
            else                                 rr_q <= gnt_q + REQ_ID_W'(1);
`endif
            state_q <= DONE;
          end
        end
        DONE: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ack_o      = ack_q;
  assign bus.req_rdata_o    = rdata_q;
  assign bus.busy_o         = busy_q;
  assign bus.gnt_id_o       = gnt_q;
  assign bus.ram_wr_o       = ram_wr_q;
  assign bus.ram_wr_data_o  = wr_data_q;
  assign bus.ram_wr_index_o = wr_index_q;
  assign bus.ram_rd_o       = ram_rd_q;
  assign bus.ram_rd_index_o = rd_index_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a 1-cycle registered-ack ram model.
module tb_ram_arbiter;

  localparam int unsigned NUM_REQ     = 2;
  localparam int unsigned WORD_WIDTH  = 4;
  localparam int unsigned INDEX_WIDTH = 4;
  localparam int unsigned REQ_ID_W    = 1;

  typedef struct {
    logic                   we;
    logic [INDEX_WIDTH-1:0] idx;
    logic [WORD_WIDTH-1:0]  data;
  } cmd_t;

  typedef struct {
    int unsigned           id;
    logic                  we;
    logic [WORD_WIDTH-1:0] data;
    int                    ack_cyc;
  } exp_t;

  logic clk_i   = 1'b0;
  logic arstn_i = 1'b0;

  always #5 clk_i = ~clk_i;

  ram_arbiter_if #(
    .NUM_REQ(NUM_REQ), .WORD_WIDTH(WORD_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH), .REQ_ID_W(REQ_ID_W)
  ) bus ();

  ram_arbiter #(
    .NUM_REQ(NUM_REQ), .WORD_WIDTH(WORD_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH), .REQ_ID_W(REQ_ID_W)
  ) dut (
    .clk_i  (clk_i),
    .arstn_i(arstn_i),
    .bus    (bus)
  );

  // Ram model: acks one cycle after the strobe unless stalled; stalled ops stay pending.
  logic [WORD_WIDTH-1:0] mem [16];
  logic                  ram_stall;
  logic                  inj_rd_ack;
  logic                  pend_wr_q, pend_rd_q, ack_wr_q, ack_rd_q;
  logic [WORD_WIDTH-1:0] rd_data_q;
  logic                  pw, pr;

  assign pw = pend_wr_q | bus.ram_wr_o;
  assign pr = pend_rd_q | bus.ram_rd_o;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      pend_wr_q <= 1'b0;
      pend_rd_q <= 1'b0;
      ack_wr_q  <= 1'b0;
      ack_rd_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (bus.ram_wr_o) mem[bus.ram_wr_index_o] <= bus.ram_wr_data_o;
      ack_wr_q  <= pw && !ram_stall;
      pend_wr_q <= pw && ram_stall;
      ack_rd_q  <= pr && !ram_stall;
      pend_rd_q <= pr && ram_stall;
      if (pr && !ram_stall) rd_data_q <= mem[bus.ram_rd_index_o];
    end
  end

  assign bus.ram_ack_wr_i  = ack_wr_q;
  assign bus.ram_ack_rd_i  = ack_rd_q | inj_rd_ack;
  assign bus.ram_rd_data_i = rd_data_q;

  cmd_t                  cmd0_q[$];
  cmd_t                  cmd1_q[$];
  exp_t                  exp_q[$];
  logic [WORD_WIDTH-1:0] ref_mem [16];
  int                    cyc;
  int                    n_checks;
  int                    n_errors;
  logic                  both_hi, long_strobe, wr_prev, rd_prev;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic drive();
    if (cmd0_q.size() > 0) begin
      bus.req_i[0]       = 1'b1;
      bus.req_we_i[0]    = cmd0_q[0].we;
      bus.req_index_i[0] = cmd0_q[0].idx;
      bus.req_wdata_i[0] = cmd0_q[0].data;
    end else begin
      bus.req_i[0] = 1'b0;
    end
    if (cmd1_q.size() > 0) begin
      bus.req_i[1]       = 1'b1;
      bus.req_we_i[1]    = cmd1_q[0].we;
      bus.req_index_i[1] = cmd1_q[0].idx;
      bus.req_wdata_i[1] = cmd1_q[0].data;
    end else begin
      bus.req_i[1] = 1'b0;
    end
  endtask

  // One cycle: sample at negedge, score any ack, retire its command, drive next inputs.
  task automatic tick();
    exp_t e;
    @(negedge clk_i);
    cyc++;
    if (bus.ram_wr_o && bus.ram_rd_o) both_hi = 1'b1;
    if ((bus.ram_wr_o && wr_prev) || (bus.ram_rd_o && rd_prev)) long_strobe = 1'b1;
    wr_prev = bus.ram_wr_o;
    rd_prev = bus.ram_rd_o;
    if (bus.req_ack_o != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(bus.req_ack_o), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("ack_vec", 32'(bus.req_ack_o), 32'(1) << e.id);
        check("gnt_id", 32'(bus.gnt_id_o), e.id);
        if (!e.we) check("rdata", 32'(bus.req_rdata_o), 32'(e.data));
        if (e.ack_cyc > 0) check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
      end
      if (bus.req_ack_o[0] && cmd0_q.size() > 0) cmd0_q.delete(0);
      if (bus.req_ack_o[1] && cmd1_q.size() > 0) cmd1_q.delete(0);
    end
    drive();
  endtask

  // Queue a command and its expected completion; call in predicted service order.
  task automatic txn(input int unsigned id, input logic we, input logic [3:0] idx,
                     input logic [3:0] data, input int ack_cyc);
    cmd_t c;
    exp_t e;
    c.we = we; c.idx = idx; c.data = data;
    if (id == 0) cmd0_q.push_back(c);
    else         cmd1_q.push_back(c);
    if (we) ref_mem[idx] = data;
    e.id = id; e.we = we; e.data = ref_mem[idx]; e.ack_cyc = ack_cyc;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cmd0_q.size() != 0 || cmd1_q.size() != 0) && n < max_cyc) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'(0));
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},      32'(bus.req_ack_o),      32'(0));
    check({tag, "_rdata"},    32'(bus.req_rdata_o),    32'(0));
    check({tag, "_busy"},     32'(bus.busy_o),         32'(0));
    check({tag, "_gnt"},      32'(bus.gnt_id_o),       32'(0));
    check({tag, "_wr"},       32'(bus.ram_wr_o),       32'(0));
    check({tag, "_rd"},       32'(bus.ram_rd_o),       32'(0));
    check({tag, "_wr_data"},  32'(bus.ram_wr_data_o),  32'(0));
    check({tag, "_wr_index"}, 32'(bus.ram_wr_index_o), 32'(0));
    check({tag, "_rd_index"}, 32'(bus.ram_rd_index_o), 32'(0));
  endtask

  initial begin
    int c;
    cmd_t rc;
    cyc = 0; n_checks = 0; n_errors = 0;
    both_hi = 1'b0; long_strobe = 1'b0; wr_prev = 1'b0; rd_prev = 1'b0;
    ram_stall = 1'b0; inj_rd_ack = 1'b0;
    bus.req_i = '0; bus.req_we_i = '0; bus.req_index_i = '0; bus.req_wdata_i = '0;

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    arstn_i = 1'b1;
    tick(); tick();

    // Single write then read by req0, with strobe timing
    c = cyc;
    txn(0, 1'b1, 4'd3, 4'hA, c + 4);
    tick(); tick();
    check("wr_strobe",   32'(bus.ram_wr_o),       32'(1));
    check("wr_no_rd",    32'(bus.ram_rd_o),       32'(0));
    check("wr_index",    32'(bus.ram_wr_index_o), 32'(3));
    check("wr_data",     32'(bus.ram_wr_data_o),  32'hA);
    check("wr_busy",     32'(bus.busy_o),         32'(1));
    tick();
    check("wr_strobe_1cyc", 32'(bus.ram_wr_o), 32'(0));
    drain(20);
    c = cyc;
    txn(0, 1'b0, 4'd3, 4'h0, c + 4);
    tick(); tick();
    check("rd_strobe", 32'(bus.ram_rd_o),       32'(1));
    check("rd_index",  32'(bus.ram_rd_index_o), 32'(3));
    drain(20);
    check("idle_busy", 32'(bus.busy_o), 32'(0));

    // Move pointer to 0, then contention: req0 wins, req1 four cycles later
    txn(1, 1'b1, 4'd8, 4'h1, 0);
    drain(20);
    c = cyc;
    txn(0, 1'b1, 4'd9,  4'h2, c + 4);
    txn(1, 1'b1, 4'd10, 4'h3, c + 8);
    drain(30);

    // Pointer to 1, contention again: round-robin serves req1 first
    txn(0, 1'b1, 4'd11, 4'h4, 0);
    drain(20);
    c = cyc;
`ifdef RAM_ARB_FIXED_PRIO_EN
    txn(0, 1'b1, 4'd13, 4'h6, c + 4);
    txn(1, 1'b1, 4'd12, 4'h5, c + 8);
`else
    txn(1, 1'b1, 4'd12, 4'h5, c + 4);
    txn(0, 1'b1, 4'd13, 4'h6, c + 8);
`endif
    drain(30);

    // Back-to-back: req0 writes 0..2, then req1 holds req through three reads
    c = cyc;
    txn(0, 1'b1, 4'd0, 4'h5, c + 4);
    txn(0, 1'b1, 4'd1, 4'h6, c + 8);
    txn(0, 1'b1, 4'd2, 4'h7, c + 12);
    drain(40);
    c = cyc;
    txn(1, 1'b0, 4'd0, 4'h0, c + 4);
    txn(1, 1'b0, 4'd1, 4'h0, c + 8);
    txn(1, 1'b0, 4'd2, 4'h0, c + 12);
    drain(40);

    // Starvation: req0 keeps requesting, req1 asks once
    c = cyc;
`ifdef RAM_ARB_FIXED_PRIO_EN
    txn(0, 1'b1, 4'd12, 4'h1, c + 4);
    txn(0, 1'b1, 4'd13, 4'h2, c + 8);
    txn(0, 1'b1, 4'd14, 4'h3, c + 12);
    txn(0, 1'b1, 4'd15, 4'h4, c + 16);
    txn(1, 1'b1, 4'd4,  4'hC, c + 20);
`else
    txn(0, 1'b1, 4'd12, 4'h1, c + 4);
    txn(1, 1'b1, 4'd4,  4'hC, c + 8);
    txn(0, 1'b1, 4'd13, 4'h2, c + 12);
    txn(0, 1'b1, 4'd14, 4'h3, c + 16);
    txn(0, 1'b1, 4'd15, 4'h4, c + 20);
`endif
    drain(50);

    // Mismatched ack: a read ack during a write must not complete it
    ram_stall = 1'b1;
    txn(0, 1'b1, 4'd5, 4'h9, 0);
    tick(); tick(); tick();
    check("wait_busy", 32'(bus.busy_o), 32'(1));
    inj_rd_ack = 1'b1;
    tick();
    inj_rd_ack = 1'b0;
    check("mismatch_no_ack0", 32'(bus.req_ack_o), 32'(0));
    tick();
    check("mismatch_no_ack1", 32'(bus.req_ack_o), 32'(0));
    check("mismatch_busy",    32'(bus.busy_o),    32'(1));
    ram_stall = 1'b0;
    drain(20);

    // Reset in WAIT: outputs clear at once, no late ack, pointer back to 0
    ram_stall = 1'b1;
    rc.we = 1'b1; rc.idx = 4'd6; rc.data = 4'hF;
    cmd1_q.push_back(rc);
    tick(); tick(); tick();
    check("pre_rst_busy", 32'(bus.busy_o),   32'(1));
    check("pre_rst_gnt",  32'(bus.gnt_id_o), 32'(1));
    arstn_i = 1'b0;
    #1;
    check_all_zero("midrst");
    cmd1_q.delete();
    ram_stall = 1'b0;
    tick(); tick();
    arstn_i = 1'b1;
    repeat (6) tick();
    check("post_rst_busy", 32'(bus.busy_o), 32'(0));
    c = cyc;
    txn(0, 1'b1, 4'd7, 4'h3, c + 4);
    txn(1, 1'b1, 4'd9, 4'hE, c + 8);
    drain(30);

    check("no_both_strobes", 32'(both_hi),     32'(0));
    check("strobe_1cyc",     32'(long_strobe), 32'(0));
    check("cmds_left", 32'(cmd0_q.size() + cmd1_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
